hmc_mem_link_init_fsm: RTL and testbench
========================================

// Module: hmc_mem_link_init_fsm
// PURPOSE
//  Memory-side (HMC-model) link-init and power-state sequencer for the HMC_Mem agent.
//  Replaces the fixed tNULL delay with a synthesizable, parametrised FSM that:
//   - drives NULL/TS1/data onto the link toward the controller;
//   - detects TS1 per lane, including per-lane polarity inversion;
//   - handles LXRXPS sleep/wake;
//   - flags init timeout on FERR_N.
//  Sits between the PHY-side data buses and the memory response model.
// PARAMETERS
//  DWIDTH          256    link data width; must be a multiple of NUM_LANES
//  NUM_LANES       8      lane count; LANE_W = DWIDTH/NUM_LANES
//  TS1_WORD        'hF0   per-lane TS1 pattern, LANE_W bits
//  T_NULL_CYC      55     NULL flits sent in NULL1 and NULL2 (220ns at 4ns clk)
//  TS1_MATCH_CNT   4      consecutive all-lane TS1 cycles required to leave TS1
//  T_TS1_TIMEOUT   1024   cycles allowed in TS1 before error
// PORTS
//  hmc_clk        in   1          clock
//  hmc_res_n      in   1          async active-low reset
//  P_RST_N        in   1          HMC reset from controller, active low
//  LXRXPS         in   1          controller power-state request (1 = active)
//  LXTXPS         out  1          memory power-state indication (1 = active)
//  FERR_N         out  1          fatal error, active low
//  rx_data        in   DWIDTH     data from controller TX (phy_data_tx_link2phy side)
//  tx_data        out  DWIDTH     data to controller RX (phy_data_rx_phy2link side)
//  app_tx_data    in   DWIDTH     response-model data, sent only in ACTIVE
//  app_rx_data    out  DWIDTH     rx_data with lane inversion applied, registered
//  lane_inv       out  NUM_LANES  per-lane polarity-inverted flags
//  link_up        out  1          high only in ACTIVE
// BEHAVIOUR
//  Reset (hmc_res_n=0, async) forces:
//   state=IDLE; LXTXPS=0; FERR_N=1; tx_data=0; app_rx_data=0; lane_inv=0; link_up=0; counters=0.
//  Outputs are registered: a state change is visible one cycle after the condition is sampled.
//  Lane slice i = bits [i*LANE_W +: LANE_W].
//  States and transitions:
//   IDLE:   tx_data=0, LXTXPS=0. P_RST_N=1 -> NULL1.
//   NULL1:  tx_data=0, LXTXPS=1. After T_NULL_CYC cycles -> TS1. Clears lane_inv on entry.
//   TS1:    tx_data={NUM_LANES{TS1_WORD}}. Each cycle, for each lane:
//            - slice == TS1_WORD  -> lane ok;
//            - slice == ~TS1_WORD -> lane ok, lane_inv[i] set (sticky until NULL1).
//           All lanes ok for TS1_MATCH_CNT consecutive cycles -> NULL2.
//           Any non-ok cycle resets the match count to 0.
//           Timeout counter reaching T_TS1_TIMEOUT -> ERR (takes priority on the same cycle).
//   NULL2:  tx_data=0 for T_NULL_CYC cycles -> ACTIVE.
//   ACTIVE: tx_data=app_tx_data; link_up=1. LXRXPS=0 -> SLEEP.
//   SLEEP:  tx_data=0, LXTXPS=0, link_up=0. LXRXPS=1 -> NULL1 (full retrain).
//   ERR:    FERR_N=0, tx_data=0, LXTXPS=1. Exit only via P_RST_N=0.
//  P_RST_N=0 sampled in any state -> IDLE next cycle; overrides all other transitions.
//  app_rx_data = rx_data with slice i XORed by {LANE_W{lane_inv[i]}}; one-cycle latency; all states.
//  Counters are $clog2(max+1) wide, saturate, and clear on every state entry.
//  LXRXPS is ignored outside ACTIVE/SLEEP.
// TESTING
//  1. Release P_RST_N, loop TS1 back -> tx=0 for 55 cyc; TS1 after 4 match cycles;
//     55 cyc NULL; link_up=1 at cycle 1+55+N+4+55.
//  2. Lanes 2 and 5 sent ~0xF0 in TS1 -> lane_inv=8'b0010_0100; app_rx_data lanes 2/5 re-inverted.
//  3. Matches for 3 cyc, 1 bad cyc, then 4 good -> stays TS1 until 4 consecutive; then NULL2.
//  4. No TS1 from controller -> FERR_N=0 exactly 1024 cyc after TS1 entry; P_RST_N=0 -> IDLE, FERR_N=1.
//  5. ACTIVE, LXRXPS=0 -> LXTXPS=0, link_up=0 next cycle;
//     LXRXPS=1 -> NULL1 retrain, lane_inv cleared.
//  6. hmc_res_n low mid-TS1 -> all outputs at reset values immediately (async), state IDLE.

Source files
------------

// File: rtl/hmc_mem_link_init_fsm.sv
// Memory-side HMC link bring-up and power-state sequencer: NULL/TS1 training with
// per-lane polarity detection, LXRXPS sleep/wake, and init-timeout reporting on FERR_N.
module hmc_mem_link_init_fsm #(
    parameter int                           DWIDTH        = 256,
    parameter int                           NUM_LANES     = 8,
    parameter logic [DWIDTH/NUM_LANES-1:0]  TS1_WORD      = 'hF0,
    parameter int                           T_NULL_CYC    = 55,
    parameter int                           TS1_MATCH_CNT = 4,
    parameter int                           T_TS1_TIMEOUT = 1024
) (
    input  logic                  hmc_clk,
    input  logic                  hmc_res_n,
    input  logic                  P_RST_N,
    input  logic                  LXRXPS,
    output logic                  LXTXPS,
    output logic                  FERR_N,
    input  logic [DWIDTH-1:0]     rx_data,
    output logic [DWIDTH-1:0]     tx_data,
    input  logic [DWIDTH-1:0]     app_tx_data,
    output logic [DWIDTH-1:0]     app_rx_data,
    output logic [NUM_LANES-1:0]  lane_inv,
    output logic                  link_up
);

    localparam int LANE_W  = DWIDTH / NUM_LANES;
    localparam int CNT_MAX = (T_NULL_CYC > T_TS1_TIMEOUT) ? T_NULL_CYC : T_TS1_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int MATCH_W = $clog2(TS1_MATCH_CNT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NULL1,
        ST_TS1,
        ST_NULL2,
        ST_ACTIVE,
        ST_SLEEP,
        ST_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MATCH_W-1:0]    match_q, match_d;
    logic [NUM_LANES-1:0]  lane_inv_q, lane_inv_d;
    logic [DWIDTH-1:0]     tx_data_q, tx_data_d;
    logic [DWIDTH-1:0]     app_rx_data_q, app_rx_data_d;
    logic                  lxtxps_q, lxtxps_d;
    logic                  ferr_n_q, ferr_n_d;
    logic                  link_up_q, link_up_d;

    logic [NUM_LANES-1:0]  lane_ok;
    logic [NUM_LANES-1:0]  lane_neg;
    logic                  all_ok;
    logic [DWIDTH-1:0]     inv_mask;

    // A lane is trained if it carries TS1 either straight or polarity-flipped.
    always_comb begin
        lane_ok  = '0;
        lane_neg = '0;
        inv_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_neg[i] = (rx_data[i*LANE_W +: LANE_W] == ~TS1_WORD);
            lane_ok[i]  = (rx_data[i*LANE_W +: LANE_W] == TS1_WORD) || lane_neg[i];
            inv_mask[i*LANE_W +: LANE_W] = {LANE_W{lane_inv_q[i]}};
        end
        all_ok = &lane_ok;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (P_RST_N) state_d = ST_NULL1;
            ST_NULL1:  if (cnt_q == CNT_W'(T_NULL_CYC - 1)) state_d = ST_TS1;
            ST_TS1: begin
                if (cnt_q == CNT_W'(T_TS1_TIMEOUT - 1))
                    state_d = ST_ERR;
                else if (all_ok && (match_q == MATCH_W'(TS1_MATCH_CNT - 1)))
                    state_d = ST_NULL2;
            end
            ST_NULL2:  if (cnt_q == CNT_W'(T_NULL_CYC - 1)) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!LXRXPS) state_d = ST_SLEEP;
            ST_SLEEP:  if (LXRXPS) state_d = ST_NULL1;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
        if (!P_RST_N)
            state_d = ST_IDLE;

        cnt_d   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        match_d = match_q;
        if (state_q == ST_TS1) begin
            if (!all_ok)
                match_d = '0;
            else if (match_q != MATCH_W'(TS1_MATCH_CNT))
                match_d = match_q + MATCH_W'(1);
        end
        if (state_d != state_q) begin
            cnt_d   = '0;
            match_d = '0;
        end

        lane_inv_d = lane_inv_q;
        if (state_q == ST_TS1)
            lane_inv_d = lane_inv_q | lane_neg;
        if ((state_d == ST_NULL1) && (state_q != ST_NULL1))
            lane_inv_d = '0;

        // Outputs follow the next state so they land together with the state change.
        tx_data_d = '0;
        lxtxps_d  = 1'b0;
        ferr_n_d  = 1'b1;
        link_up_d = 1'b0;
        unique case (state_d)
            ST_NULL1:  lxtxps_d = 1'b1;
            ST_TS1: begin
                lxtxps_d  = 1'b1;
                tx_data_d = {NUM_LANES{TS1_WORD}};
            end
            ST_NULL2:  lxtxps_d = 1'b1;
            ST_ACTIVE: begin
                lxtxps_d  = 1'b1;
                link_up_d = 1'b1;
                tx_data_d = app_tx_data;
            end
            ST_ERR: begin
                lxtxps_d = 1'b1;
                ferr_n_d = 1'b0;
            end
            default: lxtxps_d = 1'b0;
        endcase

        app_rx_data_d = rx_data ^ inv_mask;
    end

    always_ff @(posedge hmc_clk or negedge hmc_res_n) begin
        if (!hmc_res_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            match_q       <= '0;
            lane_inv_q    <= '0;
            tx_data_q     <= '0;
            app_rx_data_q <= '0;
            lxtxps_q      <= 1'b0;
            ferr_n_q      <= 1'b1;
            link_up_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            match_q       <= match_d;
            lane_inv_q    <= lane_inv_d;
            tx_data_q     <= tx_data_d;
            app_rx_data_q <= app_rx_data_d;
            lxtxps_q      <= lxtxps_d;
            ferr_n_q      <= ferr_n_d;
            link_up_q     <= link_up_d;
        end
    end

    assign LXTXPS      = lxtxps_q;
    assign FERR_N      = ferr_n_q;
    assign tx_data     = tx_data_q;
    assign app_rx_data = app_rx_data_q;
    assign lane_inv    = lane_inv_q;
    assign link_up     = link_up_q;

endmodule

// File: tb/tb_hmc_mem_link_init_fsm.sv
// Directed bench for hmc_mem_link_init_fsm: training, lane inversion, match restart,
// init timeout, sleep/wake retrain and async reset, checked through an expectation queue.
module tb_hmc_mem_link_init_fsm;

    localparam int DW = 256;
    localparam int NL = 8;
    localparam int LW = DW / NL;
    localparam logic [LW-1:0] TS1 = 32'h0000_00F0;

    logic           hmc_clk = 1'b0;
    logic           hmc_res_n;
    logic           p_rst_n;
    logic           lxrxps;
    logic           loop_en;
    logic [DW-1:0]  rx_drv;
    logic [DW-1:0]  app_tx_data;
    logic [DW-1:0]  rx_data;
    logic [DW-1:0]  tx_data;
    logic [DW-1:0]  app_rx_data;
    logic           lxtxps;
    logic           ferr_n;
    logic           link_up;
    logic [NL-1:0]  lane_inv;

    logic [DW-1:0]  ts1_all;
    logic [DW-1:0]  inv_pat;
    logic [DW-1:0]  bad_pat;
    logic [DW-1:0]  rx_pat;
    logic [DW-1:0]  rx_flip;
    logic [DW-1:0]  app_d1;
    logic [DW-1:0]  app_d2;

    int             exp_kind_q[$];
    logic [DW-1:0]  exp_val_q[$];
    string          exp_tag_q[$];
    int             pass_cnt = 0;
    int             total_cnt = 0;

    assign rx_data = loop_en ? tx_data : rx_drv;

    always #2 hmc_clk = ~hmc_clk;

    hmc_mem_link_init_fsm dut (
        .hmc_clk     (hmc_clk),
        .hmc_res_n   (hmc_res_n),
        .P_RST_N     (p_rst_n),
        .LXRXPS      (lxrxps),
        .LXTXPS      (lxtxps),
        .FERR_N      (ferr_n),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .app_tx_data (app_tx_data),
        .app_rx_data (app_rx_data),
        .lane_inv    (lane_inv),
        .link_up     (link_up)
    );

    function automatic logic [DW-1:0] observe(input int kind);
        case (kind)
            0:       return {{(DW-NL-3){1'b0}}, lxtxps, ferr_n, link_up, lane_inv};
            1:       return tx_data;
            default: return app_rx_data;
        endcase
    endfunction

    task automatic expectCtl(input string tag, input logic lx, input logic fe,
                             input logic lu, input logic [NL-1:0] li);
        exp_kind_q.push_back(0);
        exp_val_q.push_back({{(DW-NL-3){1'b0}}, lx, fe, lu, li});
        exp_tag_q.push_back(tag);
    endtask

    task automatic expectTx(input string tag, input logic [DW-1:0] v);
        exp_kind_q.push_back(1);
        exp_val_q.push_back(v);
        exp_tag_q.push_back(tag);
    endtask

    task automatic expectRx(input string tag, input logic [DW-1:0] v);
        exp_kind_q.push_back(2);
        exp_val_q.push_back(v);
        exp_tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        int            kind;
        logic [DW-1:0] exp_v;
        logic [DW-1:0] obs_v;
        string         tag;
        while (exp_kind_q.size() > 0) begin
            kind  = exp_kind_q.pop_front();
            exp_v = exp_val_q.pop_front();
            tag   = exp_tag_q.pop_front();
            obs_v = observe(kind);
            total_cnt = total_cnt + 1;
            assert (obs_v === exp_v) pass_cnt = pass_cnt + 1;
            else $error("[TB] FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic lx, input logic [DW-1:0] rxv,
                                 input logic [DW-1:0] app);
        p_rst_n     = p;
        lxrxps      = lx;
        rx_drv      = rxv;
        app_tx_data = app;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge hmc_clk);
        #1;
    endtask

    initial begin
        ts1_all = {NL{TS1}};
        inv_pat = ts1_all;
        inv_pat[2*LW +: LW] = ~TS1;
        inv_pat[5*LW +: LW] = ~TS1;
        bad_pat = ts1_all;
        bad_pat[0 +: LW] = 32'h1234_5678;
        rx_pat  = {8{32'hA5C3_0F96}} ^ {4{64'h0123_4567_89AB_CDEF}};
        rx_flip = rx_pat;
        rx_flip[2*LW +: LW] = ~rx_pat[2*LW +: LW];
        rx_flip[5*LW +: LW] = ~rx_pat[5*LW +: LW];
        app_d1  = {4{64'hDEAD_BEEF_0BAD_F00D}};
        app_d2  = {8{32'h5A5A_3C3C}};

        hmc_res_n = 1'b0;
        loop_en   = 1'b0;
        applyStimulus(1'b0, 1'b1, rx_pat, app_d1);
        #3;
        expectCtl("reset_ctl", 1'b0, 1'b1, 1'b0, 8'h00);
        expectTx("reset_tx", '0);
        expectRx("reset_apprx", '0);
        checkOutput();
        #4 hmc_res_n = 1'b1;
        tick(3);
        expectCtl("idle_hold_ctl", 1'b0, 1'b1, 1'b0, 8'h00);
        expectTx("idle_hold_tx", '0);
        checkOutput();

        $display("[TB] normal training with loopback");
        applyStimulus(1'b1, 1'b1, '0, app_d1);
        loop_en = 1'b1;
        tick(1);
        expectCtl("null1_entry_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        expectTx("null1_entry_tx", '0);
        checkOutput();
        tick(54);
        expectTx("null1_last_tx", '0);
        checkOutput();
        tick(1);
        expectTx("ts1_entry_tx", ts1_all);
        expectCtl("ts1_entry_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput();
        tick(3);
        expectTx("ts1_match3_tx", ts1_all);
        checkOutput();
        tick(1);
        expectTx("null2_entry_tx", '0);
        expectCtl("null2_entry_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput();
        tick(54);
        expectCtl("null2_last_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput();
        tick(1);
        expectCtl("active_entry_ctl", 1'b1, 1'b1, 1'b1, 8'h00);
        expectTx("active_entry_tx", app_d1);
        checkOutput();
        loop_en = 1'b0;
        applyStimulus(1'b1, 1'b1, rx_pat, app_d2);
        tick(1);
        expectTx("active_app_tx", app_d2);
        expectRx("active_apprx_plain", rx_pat);
        checkOutput();

        $display("[TB] sleep then retrain with lanes 2 and 5 inverted");
        applyStimulus(1'b1, 1'b0, inv_pat, app_d2);
        tick(1);
        expectCtl("sleep_entry_ctl", 1'b0, 1'b1, 1'b0, 8'h00);
        expectTx("sleep_entry_tx", '0);
        checkOutput();
        tick(2);
        expectCtl("sleep_hold_ctl", 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput();
        applyStimulus(1'b1, 1'b1, inv_pat, app_d2);
        tick(1);
        expectCtl("wake_null1_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput();
        tick(55);
        expectTx("inv_ts1_entry_tx", ts1_all);
        expectCtl("inv_ts1_entry_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput();
        tick(1);
        expectCtl("lane_inv_set", 1'b1, 1'b1, 1'b0, 8'b0010_0100);
        checkOutput();
        tick(3);
        expectTx("inv_null2_tx", '0);
        checkOutput();
        tick(55);
        expectCtl("inv_active_ctl", 1'b1, 1'b1, 1'b1, 8'b0010_0100);
        checkOutput();
        applyStimulus(1'b1, 1'b1, rx_pat, app_d2);
        tick(1);
        expectRx("apprx_reinverted", rx_flip);
        checkOutput();
        applyStimulus(1'b1, 1'b0, rx_pat, app_d2);
        tick(1);
        expectCtl("sleep2_ctl", 1'b0, 1'b1, 1'b0, 8'b0010_0100);
        checkOutput();
        applyStimulus(1'b1, 1'b1, ts1_all, app_d2);
        tick(1);
        expectCtl("retrain_inv_cleared", 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput();

        $display("[TB] match run broken by one bad cycle");
        tick(55);
        expectTx("mr_ts1_entry_tx", ts1_all);
        checkOutput();
        tick(3);
        applyStimulus(1'b1, 1'b1, bad_pat, app_d2);
        tick(1);
        expectTx("mr_after_bad_tx", ts1_all);
        checkOutput();
        applyStimulus(1'b1, 1'b1, ts1_all, app_d2);
        tick(3);
        expectTx("mr_three_good_tx", ts1_all);
        checkOutput();
        tick(1);
        expectTx("mr_null2_tx", '0);
        expectCtl("mr_null2_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput();

        $display("[TB] P_RST_N override and TS1 timeout");
        applyStimulus(1'b0, 1'b1, '0, app_d2);
        tick(1);
        expectCtl("prst_override_ctl", 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput();
        applyStimulus(1'b1, 1'b1, '0, app_d2);
        tick(56);
        expectTx("to_ts1_entry_tx", ts1_all);
        checkOutput();
        tick(1023);
        expectCtl("to_before_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        expectTx("to_before_tx", ts1_all);
        checkOutput();
        tick(1);
        expectCtl("to_ferr_ctl", 1'b1, 1'b0, 1'b0, 8'h00);
        expectTx("to_ferr_tx", '0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, ts1_all, app_d2);
        tick(3);
        expectCtl("err_sticky_ctl", 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput();
        applyStimulus(1'b0, 1'b1, '0, app_d2);
        tick(1);
        expectCtl("err_exit_ctl", 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput();

        $display("[TB] async reset in the middle of TS1");
        applyStimulus(1'b1, 1'b1, inv_pat, app_d2);
        tick(56);
        tick(2);
        expectCtl("pre_reset_ctl", 1'b1, 1'b1, 1'b0, 8'b0010_0100);
        checkOutput();
        #1 hmc_res_n = 1'b0;
        #1;
        expectCtl("async_reset_ctl", 1'b0, 1'b1, 1'b0, 8'h00);
        expectTx("async_reset_tx", '0);
        expectRx("async_reset_apprx", '0);
        checkOutput();
        hmc_res_n = 1'b1;
        tick(1);
        expectCtl("post_reset_null1_ctl", 1'b1, 1'b1, 1'b0, 8'h00);
        expectTx("post_reset_null1_tx", '0);
        checkOutput();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
